// File: rtl/regfile_ext.sv
// Register file with two registered read ports, a load-extending write port,
// optional write-to-read bypass and a pending-load busy scoreboard.
module regfile_ext #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        wr_mode,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic              rs_busy_q, rt_busy_q;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
  logic              wr_live;

  always_comb begin
    ext = wr_data;
    case (wr_mode)
      3'b001:  ext = {{(DATA_W-8){1'b0}}, wr_data[7:0]};
      3'b010:  ext = {{(DATA_W-16){1'b0}}, wr_data[15:0]};
      3'b101:  ext = {{(DATA_W-8){wr_data[7]}}, wr_data[7:0]};
      3'b110:  ext = {{(DATA_W-16){wr_data[15]}}, wr_data[15:0]};
      default: ext = wr_data;
    endcase
  end

  assign wr_live = wr_en && (wr_addr != '0);

  // Write clears first, issue sets second, so a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[wr_addr]  = 1'b0;
    if (iss_en) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_comb begin
    rs_data_d = mem_q[rs_addr];
    if (rs_addr == '0) rs_data_d = '0;
    else if ((BYPASS != 0) && wr_en && (wr_addr == rs_addr)) rs_data_d = ext;
    rt_data_d = mem_q[rt_addr];
    if (rt_addr == '0) rt_data_d = '0;
    else if ((BYPASS != 0) && wr_en && (wr_addr == rt_addr)) rt_data_d = ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      rs_busy_q  <= 1'b0;
      rt_busy_q  <= 1'b0;
    end else begin
      if (wr_live) mem_q[wr_addr] <= ext;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      if (rd_en) begin
        rs_data_q <= rs_data_d;
        rt_data_q <= rt_data_d;
        rs_busy_q <= busy_d[rs_addr];
        rt_busy_q <= busy_d[rt_addr];
      end
    end
  end

  assign rs_data  = rs_data_q;
  assign rt_data  = rt_data_q;
  assign rs_busy  = rs_busy_q;
  assign rt_busy  = rt_busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule
